dot_engine: RTL and testbench
=============================

# dot_engine

Fixed-point dot-product engine that sits directly downstream of the DNN layer controller. The controller programs a weight-row base address, an activation-vector base address and a length through an Avalon-MM slave, then starts the engine. The engine streams both vectors from SDRAM through its Avalon-MM master and accumulates their Q16.16 product sum. It returns the sum on a blocking read of register 0; the controller then adds the bias and applies the activation function.

## Interface
Parameters:
- `ADDR_W`, 32: master address width.
- `FRAC_BITS`, 16: fractional bits of the Q16.16 format.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: synchronous, active-high reset (port name kept per codebase convention; asserted = 1, sampled on `clk` rising edge).
- `slave_waitrequest`  out  1: slave stall.
- `slave_address`  in  4: register word offset.
- `slave_read`  in  1: slave read strobe.
- `slave_readdata`  out  32: slave read data.
- `slave_write`  in  1: slave write strobe.
- `slave_writedata`  in  32: slave write data.
- `master_waitrequest`  in  1: SDRAM stall.
- `master_address`  out  `ADDR_W`: byte address.
- `master_read`  out  1: master read strobe.
- `master_readdata`  in  32: SDRAM read data.
- `master_readdatavalid`  in  1: read data valid.
- `master_write`  out  1: tied 0.
- `master_writedata`  out  32: tied 0.

## Operation
- Registers (word offset):
  - 0: write = start (data ignored); read = result, blocks until done.
  - 2: weight base address.
  - 3: activation base address.
  - 5: length N (elements).
  - Writes to other offsets are acknowledged and ignored; reads of other offsets return 0.
- States:
  - IDLE → RD_W on start.
  - RD_W: issue read at `wbase + 4*i`; → WAIT_W when `master_waitrequest`=0.
  - WAIT_W: on `readdatavalid`, latch w; → RD_A.
  - RD_A: issue read at `abase + 4*i`; → WAIT_A when accepted.
  - WAIT_A: on valid, latch a; → MAC.
  - MAC: `acc += (w*a)>>>FRAC_BITS`; `i++`; → RD_W if `i<N`, else DONE.
  - DONE: result is valid; returns to IDLE after the result read is acknowledged, or after a new start.
- Start with N=0: go directly to DONE with `acc=0`; no master traffic.
- Arithmetic:
  - Signed 32×32 → 64-bit product; take bits [47:16] (arithmetic shift, truncate toward −∞).
  - 32-bit two's-complement accumulator; wraps silently on overflow.
- `acc` and `i` clear on start. Config registers hold their values across runs.
- Reset at any point: all state and registers are cleared; the engine returns to IDLE; `master_read` drops in the same edge.

## Timing
- Reset values:
  - `slave_waitrequest`=1
  - `slave_readdata`=0
  - `master_read`=0
  - `master_address`=0
  - `master_write`=0
  - `master_writedata`=0
- `slave_waitrequest` idles at 1.
- Slave write in IDLE or DONE: one wait state; `slave_waitrequest`=0 for exactly one cycle, in the cycle after the request is first sampled. Register updates on that edge.
- Slave write while busy (RD_*/WAIT_*/MAC): `slave_waitrequest` held 1 until DONE, then acknowledged as above.
- Read of reg 0: `slave_waitrequest` held 1 until DONE; then low for one cycle with `slave_readdata`=acc valid in that same cycle.
- Master reads:
  - One outstanding read at a time.
  - `master_read` and `master_address` are registered and held stable while `master_waitrequest`=1.
  - `master_read` drops the edge after acceptance.
  - `readdatavalid` may arrive any number of cycles later, including the cycle after acceptance.
- Per element: minimum 2×(1 issue + 1 data) + 1 MAC = 5 cycles.
- Minimum start-ack to DONE: 5N+1 cycles.

## Structure
- Package `dnn_pkg`:
  - Register offset constants (`REG_CTRL`=0, `REG_WADDR`=2, `REG_AADDR`=3, `REG_LEN`=5).
  - `FRAC_BITS`.
  - State enum `dot_state_t`.
  - The `q16_mul` function.
- Optional sub-module `q16_mac` (multiply, shift, accumulate, sync clear); the remaining logic stays in `dot_engine`.

## Test plan
- N=4, all w=0x00010000 (1.0), all a=0x00020000 (2.0), zero-latency SDRAM → reg-0 read returns 0x00080000; master addresses interleave wbase, abase, wbase+4, abase+4, ….
- w=0xFFFE8000 (−1.5), a=0x00020000, N=1 → 0xFFFD0000 (−3.0).
- N=0 → reg-0 read returns 0 within 3 cycles; `master_read` never asserted.
- `master_waitrequest` held 3 cycles per read and `readdatavalid` delayed 5 cycles → same result as the first scenario; `master_address` stable throughout each stall.
- Write to reg 2 during computation → `slave_waitrequest` stays 1 until DONE; stored base address unchanged until acknowledged.
- `rst_n`=1 for one cycle mid-WAIT_A → next edge: `master_read`=0, `slave_waitrequest`=1, state IDLE, registers 0; a fresh run then yields the correct result.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN datapath blocks: register map, Q16.16 format,
// dot-engine state encoding and the fixed-point multiply helper.
package dnn_pkg;

  localparam logic [3:0] REG_CTRL  = 4'd0;
  localparam logic [3:0] REG_WADDR = 4'd2;
  localparam logic [3:0] REG_AADDR = 4'd3;
  localparam logic [3:0] REG_LEN   = 4'd5;

  localparam int FRAC_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_W,
    ST_WAIT_W,
    ST_RD_A,
    ST_WAIT_A,
    ST_MAC,
    ST_DONE
  } dot_state_t;

  // Signed 32x32 product, arithmetic right shift, low 32 bits kept (floor rounding).
  function automatic logic [31:0] q16_mul(input logic [31:0] w, input logic [31:0] a,
                                          input int frac);
    logic signed [63:0] p;
    p = $signed({{32{w[31]}}, w}) * $signed({{32{a[31]}}, a});
    return 32'(p >>> frac);
  endfunction

endpackage

// File: rtl/q16_mac.sv
// Q16.16 multiply-accumulate with a synchronous clear; the accumulator wraps on
// overflow.
module q16_mac
  import dnn_pkg::*;
#(
  parameter int SHIFT = FRAC_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [31:0] i_w,
  input  logic [31:0] i_a,
  output logic [31:0] o_acc
);

  logic [31:0] r_acc;

  // NOTE: rst_n is an active-high synchronous reset despite its name.
  always_ff @(posedge clk) begin
    if (rst_n || i_clear) r_acc <= '0;
    else if (i_en)        r_acc <= r_acc + q16_mul(i_w, i_a, SHIFT);
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dot_engine.sv
// Dot-product engine: Avalon-MM slave for configuration/result, Avalon-MM
// master streaming weight and activation vectors one element at a time.
module dot_engine
  import dnn_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int FRAC_BITS = dnn_pkg::FRAC_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [31:0]       master_writedata
);

  dot_state_t        r_state, w_next;
  logic              r_wait;
  logic [31:0]       r_rdata;
  logic              r_mread;
  logic [ADDR_W-1:0] r_maddr;
  logic [31:0]       r_wbase, r_abase, r_len, r_idx, r_w, r_a;
  logic [31:0]       w_acc, w_issue_base, w_issue_idx;
  logic              w_busy, w_ack_go, w_start, w_rd_done, w_issue, w_mac_en;

  // Writes are only taken between runs; result reads wait for DONE.
  assign w_busy    = !(r_state == ST_IDLE || r_state == ST_DONE);
  assign w_ack_go  = r_wait && ((slave_write && !w_busy) ||
                     (slave_read && (slave_address != REG_CTRL || r_state == ST_DONE)));
  assign w_start   = w_ack_go && slave_write && slave_address == REG_CTRL;
  assign w_rd_done = !r_wait && slave_read && slave_address == REG_CTRL;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    w_issue_base = r_wbase;
    w_issue_idx  = r_idx;
    w_mac_en     = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start) begin
          if (r_len == '0) begin
            w_next = ST_DONE;
          end else begin
            w_next      = ST_RD_W;
            w_issue     = 1'b1;
            w_issue_idx = '0;
          end
        end else if (r_state == ST_DONE && w_rd_done) begin
          w_next = ST_IDLE;
        end
      end
      ST_RD_W:   if (!master_waitrequest) w_next = ST_WAIT_W;
      ST_WAIT_W: if (master_readdatavalid) begin
        w_next       = ST_RD_A;
        w_issue      = 1'b1;
        w_issue_base = r_abase;
      end
      ST_RD_A:   if (!master_waitrequest) w_next = ST_WAIT_A;
      ST_WAIT_A: if (master_readdatavalid) w_next = ST_MAC;
      ST_MAC: begin
        w_mac_en = 1'b1;
        if (r_idx + 32'd1 < r_len) begin
          w_next      = ST_RD_W;
          w_issue     = 1'b1;
          w_issue_idx = r_idx + 32'd1;
        end else begin
          w_next = ST_DONE;
        end
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wait  <= 1'b1;
      r_rdata <= '0;
      r_mread <= 1'b0;
      r_maddr <= '0;
      r_wbase <= '0;
      r_abase <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_w     <= '0;
      r_a     <= '0;
    end else begin
      r_wait  <= !w_ack_go;
      r_rdata <= (w_ack_go && slave_read && slave_address == REG_CTRL) ? w_acc : '0;
      if (w_ack_go && slave_write) begin
        case (slave_address)
          REG_WADDR: r_wbase <= slave_writedata;
          REG_AADDR: r_abase <= slave_writedata;
          REG_LEN:   r_len   <= slave_writedata;
          default:   ;
        endcase
      end
      // Request and address are held until the SDRAM accepts them.
      if (w_issue) begin
        r_mread <= 1'b1;
        r_maddr <= ADDR_W'(w_issue_base + (w_issue_idx << 2));
      end else if (!master_waitrequest) begin
        r_mread <= 1'b0;
      end
      if (w_start)       r_idx <= '0;
      else if (w_mac_en) r_idx <= r_idx + 32'd1;
      if (r_state == ST_WAIT_W && master_readdatavalid) r_w <= master_readdata;
      if (r_state == ST_WAIT_A && master_readdatavalid) r_a <= master_readdata;
    end
  end

  q16_mac #(.SHIFT(FRAC_BITS)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_start),
    .i_en   (w_mac_en),
    .i_w    (r_w),
    .i_a    (r_a),
    .o_acc  (w_acc)
  );

  assign slave_waitrequest = r_wait;
  assign slave_readdata    = r_rdata;
  assign master_read       = r_mread;
  assign master_address    = r_maddr;
  assign master_write      = 1'b0;
  assign master_writedata  = '0;

endmodule

// File: tb/tb_dot_engine.sv
// Bench for dot_engine: SDRAM responder with programmable stall/latency, a
// vector-level dot-product model, and a per-cycle compare of slave/master outputs.
module tb_dot_engine;
  import dnn_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              slave_waitrequest;
  logic [3:0]        slave_address = '0;
  logic              slave_read = 1'b0;
  logic [31:0]       slave_readdata;
  logic              slave_write = 1'b0;
  logic [31:0]       slave_writedata = '0;
  logic              master_waitrequest = 1'b0;
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic [31:0]       master_readdata = '0;
  logic              master_readdatavalid = 1'b0;
  logic              master_write;
  logic [31:0]       master_writedata;

  always #5 clk = ~clk;

  dot_engine #(.ADDR_W(ADDR_W), .FRAC_BITS(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .slave_waitrequest   (slave_waitrequest),
    .slave_address       (slave_address),
    .slave_read          (slave_read),
    .slave_readdata      (slave_readdata),
    .slave_write         (slave_write),
    .slave_writedata     (slave_writedata),
    .master_waitrequest  (master_waitrequest),
    .master_address      (master_address),
    .master_read         (master_read),
    .master_readdata     (master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_write        (master_write),
    .master_writedata    (master_writedata)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_result = '0;
  int          stall_cfg = 0;
  int          lat_cfg = 0;
  int          accept_cnt = 0;
  int          mread_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] addr);
    return mem.exists(addr) ? mem[addr] : 32'h0;
  endfunction

  // Reference: sum over k of floor(w[k]*a[k] / 2^16), wrapped to 32 bits.
  function automatic logic [31:0] model_dot(input logic [31:0] wb, input logic [31:0] ab,
                                            input int n);
    logic [31:0] acc;
    longint      p;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      p   = longint'(signed'(rd_mem(wb + 32'(4 * k)))) * longint'(signed'(rd_mem(ab + 32'(4 * k))));
      acc = acc + 32'(p >>> 16);
    end
    return acc;
  endfunction

  // SDRAM: stalls each request stall_cfg cycles, returns data lat_cfg cycles
  // after the cycle following acceptance.
  initial begin : sdram
    int          stall_left, lat_left;
    bit          in_req, have_data, just_acc;
    logic [31:0] hold_addr, dat_addr;
    in_req = 0; have_data = 0; just_acc = 0; stall_left = 0; lat_left = 0;
    hold_addr = '0; dat_addr = '0;
    forever begin
      @(negedge clk);
      master_readdatavalid = 1'b0;
      if (rst_n) begin
        in_req = 0; have_data = 0; just_acc = 0;
        master_waitrequest = 1'b0;
        exp_addr_q.delete();
      end else begin
        if (just_acc) begin
          have_data = 1; lat_left = lat_cfg; just_acc = 0;
        end
        if (have_data) begin
          if (lat_left == 0) begin
            master_readdatavalid = 1'b1;
            master_readdata      = rd_mem(dat_addr);
            have_data            = 0;
          end else begin
            lat_left--;
          end
        end
        if (master_read) begin
          mread_seen++;
          if (!in_req) begin
            in_req = 1; stall_left = stall_cfg; hold_addr = master_address;
          end else begin
            check("maddr_stable", master_address, hold_addr);
          end
          if (stall_left > 0) begin
            master_waitrequest = 1'b1;
            stall_left--;
          end else begin
            master_waitrequest = 1'b0;
            in_req = 0; just_acc = 1; dat_addr = master_address;
            accept_cnt++;
            if (exp_addr_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL maddr_seq: got 0x%08h, expected no further read", master_address);
            end else begin
              check("maddr_seq", master_address, exp_addr_q.pop_front());
            end
          end
        end else begin
          master_waitrequest = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare of slave acknowledge cycles and tied-off master outputs.
  initial begin : compare
    bit prev_low;
    prev_low = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (!slave_waitrequest) begin
          check("ack_single_cycle", {31'b0, prev_low}, 32'h0);
          if (slave_read)
            check(slave_address == REG_CTRL ? "result" : "rd_other", slave_readdata,
                  slave_address == REG_CTRL ? exp_result : 32'h0);
        end
        if (master_read) check("mwrite_tied", master_writedata | {31'b0, master_write}, 32'h0);
      end
      prev_low = !slave_waitrequest;
    end
  end

  task automatic sl_write(input logic [3:0] a, input logic [31:0] d, input int budget,
                          input string name, output int cycles);
    @(negedge clk);
    slave_write = 1'b1; slave_address = a; slave_writedata = d; cycles = 0;
    do begin @(negedge clk); cycles++; end while (slave_waitrequest && cycles < budget);
    if (slave_waitrequest) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: waitrequest 1 after %0d cycles, expected 0", name, cycles);
    end
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic sl_read(input logic [3:0] a, input int budget, input string name,
                         output logic [31:0] d, output int cycles);
    @(negedge clk);
    slave_read = 1'b1; slave_address = a; cycles = 0; d = '0;
    do begin @(negedge clk); cycles++; end while (slave_waitrequest && cycles < budget);
    if (slave_waitrequest) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: waitrequest 1 after %0d cycles, expected 0", name, cycles);
    end else begin
      d = slave_readdata;
    end
    @(negedge clk);
    slave_read = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] wb, input logic [31:0] ab, input logic [31:0] n);
    int c;
    sl_write(REG_WADDR, wb, 10, "wr_waddr", c);
    sl_write(REG_AADDR, ab, 10, "wr_aaddr", c);
    sl_write(REG_LEN,   n,  10, "wr_len",   c);
  endtask

  task automatic arm(input logic [31:0] wb, input logic [31:0] ab, input int n);
    exp_result = model_dot(wb, ab, n);
    for (int k = 0; k < n; k++) begin
      exp_addr_q.push_back(wb + 32'(4 * k));
      exp_addr_q.push_back(ab + 32'(4 * k));
    end
  endtask

  task automatic start_run();
    int c;
    sl_write(REG_CTRL, 32'h0, 10, "wr_start", c);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1 rst_n = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    int          cyc, seen0, base;

    for (int k = 0; k < 4; k++) begin
      mem[32'h1000 + 32'(4 * k)] = 32'h0001_0000;
      mem[32'h2000 + 32'(4 * k)] = 32'h0002_0000;
      mem[32'h5000 + 32'(4 * k)] = 32'h0000_8000;
    end
    mem[32'h3000] = 32'hFFFE_8000;
    mem[32'h4000] = 32'h0002_0000;
    mem[32'h6000] = 32'hFFFF_FFFF; mem[32'h7000] = 32'h0000_8000;
    mem[32'h6004] = 32'h0003_0000; mem[32'h7004] = 32'hFFFF_0000;
    mem[32'h6008] = 32'h7FFF_FFFF; mem[32'h7008] = 32'h0001_0000;

    // Model pins against hand-computed values.
    check("model_4x2p0",  model_dot(32'h1000, 32'h2000, 4), 32'h0008_0000);
    check("model_neg1p5", model_dot(32'h3000, 32'h4000, 1), 32'hFFFD_0000);
    check("model_floor",  model_dot(32'h6000, 32'h7000, 3), 32'h7FFC_FFFE);
    check("model_half",   model_dot(32'h5000, 32'h2000, 4), 32'h0004_0000);

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    check("rst_waitrequest", {31'b0, slave_waitrequest}, 32'h1);
    check("rst_readdata",    slave_readdata, 32'h0);
    check("rst_mread",       {31'b0, master_read}, 32'h0);
    check("rst_maddr",       master_address, 32'h0);
    check("rst_mwrite",      {31'b0, master_write}, 32'h0);
    check("rst_mwdata",      master_writedata, 32'h0);

    // 4 x (1.0 * 2.0), zero-latency SDRAM.
    load_cfg(32'h1000, 32'h2000, 32'd4);
    arm(32'h1000, 32'h2000, 4);
    start_run();
    sl_read(REG_CTRL, 2000, "rd_s1", d, cyc);
    check("s1_result", d, 32'h0008_0000);
    check("s1_addr_left", 32'(exp_addr_q.size()), 32'h0);

    // Negative weight: -1.5 * 2.0.
    load_cfg(32'h3000, 32'h4000, 32'd1);
    arm(32'h3000, 32'h4000, 1);
    start_run();
    sl_read(REG_CTRL, 2000, "rd_s2", d, cyc);
    check("s2_result", d, 32'hFFFD_0000);

    // Floor rounding and large positive term.
    load_cfg(32'h6000, 32'h7000, 32'd3);
    arm(32'h6000, 32'h7000, 3);
    start_run();
    sl_read(REG_CTRL, 2000, "rd_floor", d, cyc);
    check("floor_result", d, 32'h7FFC_FFFE);

    // Reads of unmapped/config offsets return 0.
    sl_read(REG_WADDR, 10, "rd_reg2", d, cyc);
    check("rd_reg2_zero", d, 32'h0);

    // N=0: immediate DONE, no master traffic.
    seen0 = mread_seen;
    sl_write(REG_LEN, 32'd0, 10, "wr_len0", cyc);
    exp_result = '0;
    start_run();
    sl_read(REG_CTRL, 20, "rd_n0", d, cyc);
    check("n0_result", d, 32'h0);
    check("n0_latency_le3", {31'b0, cyc <= 3}, 32'h1);
    check("n0_no_mread", 32'(mread_seen - seen0), 32'h0);

    // Stalled SDRAM: 3 wait cycles per request, data 5 cycles late.
    stall_cfg = 3; lat_cfg = 5;
    load_cfg(32'h1000, 32'h2000, 32'd4);
    arm(32'h1000, 32'h2000, 4);
    start_run();
    sl_read(REG_CTRL, 2000, "rd_stall", d, cyc);
    check("stall_result", d, 32'h0008_0000);
    check("stall_addr_left", 32'(exp_addr_q.size()), 32'h0);

    // Base-address write during a run is held off until DONE.
    arm(32'h1000, 32'h2000, 4);
    start_run();
    sl_write(REG_WADDR, 32'h5000, 2000, "wr_busy", cyc);
    check("busy_write_blocked", {31'b0, cyc >= 20}, 32'h1);
    check("busy_addr_left", 32'(exp_addr_q.size()), 32'h0);
    sl_read(REG_CTRL, 2000, "rd_busy", d, cyc);
    check("busy_result_oldbase", d, 32'h0008_0000);
    arm(32'h5000, 32'h2000, 4);
    start_run();
    sl_read(REG_CTRL, 2000, "rd_newbase", d, cyc);
    check("newbase_result", d, 32'h0004_0000);

    // Reset while waiting for activation data.
    stall_cfg = 0; lat_cfg = 5;
    load_cfg(32'h1000, 32'h2000, 32'd4);
    arm(32'h1000, 32'h2000, 4);
    start_run();
    base = accept_cnt; cyc = 0;
    while (accept_cnt < base + 2 && cyc < 200) begin @(negedge clk); cyc++; end
    check("reached_wait_a", {31'b0, accept_cnt >= base + 2}, 32'h1);
    repeat (2) @(negedge clk);
    pulse_reset();
    check("mid_rst_mread",    {31'b0, master_read}, 32'h0);
    check("mid_rst_wait",     {31'b0, slave_waitrequest}, 32'h1);
    check("mid_rst_readdata", slave_readdata, 32'h0);
    check("mid_rst_maddr",    master_address, 32'h0);
    // Cleared length register: a bare start completes at once with no traffic.
    seen0 = mread_seen;
    exp_result = '0;
    start_run();
    sl_read(REG_CTRL, 20, "rd_after_rst", d, cyc);
    check("after_rst_result", d, 32'h0);
    check("after_rst_no_mread", 32'(mread_seen - seen0), 32'h0);
    lat_cfg = 0;
    load_cfg(32'h1000, 32'h2000, 32'd4);
    arm(32'h1000, 32'h2000, 4);
    start_run();
    sl_read(REG_CTRL, 2000, "rd_fresh", d, cyc);
    check("fresh_result", d, 32'h0008_0000);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
